// File: rtl/hadbadge_flash_arbiter_if.sv
// ---------------------------------------------------------------------------
// hadbadge_flash_arbiter_if
// Bundle of the two requester SPI ports, the shared flash pins and the
// grant/busy status of the flash arbiter.
//   slave  : seen by the arbiter (requests/pins in, grants/flash pins out)
//   master : seen by whatever drives the requesters and models the flash
// Signals:
//   m0_req/m1_req          ownership request per requester
//   m0_gnt/m1_gnt          registered grant, one-hot or zero
//   mX_cs/mX_sck/mX_mosi   requester SPI pins (cs active-low)
//   m0_miso/m1_miso        flash data returned to each requester
//   flash_cs/sck/mosi      shared flash pins (cs active-low)
//   flash_miso             flash data out
//   busy                   arbiter not idle
// ---------------------------------------------------------------------------
interface hadbadge_flash_arbiter_if;
    logic m0_req, m1_req;
    logic m0_gnt, m1_gnt;
    logic m0_cs, m0_sck, m0_mosi;
    logic m1_cs, m1_sck, m1_mosi;
    logic m0_miso, m1_miso;
    logic flash_cs, flash_sck, flash_mosi;
    logic flash_miso;
    logic busy;

    modport slave (
        input  m0_req, m1_req,
        input  m0_cs, m0_sck, m0_mosi,
        input  m1_cs, m1_sck, m1_mosi,
        input  flash_miso,
        output m0_gnt, m1_gnt,
        output m0_miso, m1_miso,
        output flash_cs, flash_sck, flash_mosi,
        output busy
    );

    modport master (
        output m0_req, m1_req,
        output m0_cs, m0_sck, m0_mosi,
        output m1_cs, m1_sck, m1_mosi,
        output flash_miso,
        input  m0_gnt, m1_gnt,
        input  m0_miso, m1_miso,
        input  flash_cs, flash_sck, flash_mosi,
        input  busy
    );
endinterface

// File: rtl/hadbadge_flash_arbiter.sv
// ---------------------------------------------------------------------------
// hadbadge_flash_arbiter
// Shares one SPI flash between the USB bootloader SPI master (m0) and a
// secondary master (m1). A requester owns the flash pins from grant until it
// has dropped its request with its chip select high; the flash chip select
// is then held high for a guard interval before anyone else can own it.
// Simultaneous requests from idle are resolved round robin.
// Ports:
//   clk     48 MHz system clock
//   resetn  asynchronous active-low reset
//   bus     hadbadge_flash_arbiter_if.slave (requests, grants, SPI pins)
// Parameter:
//   GUARD_CYCLES  cycles spent in GUARD after a release (1..255)
// ---------------------------------------------------------------------------
module hadbadge_flash_arbiter #(
    parameter int GUARD_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    hadbadge_flash_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] guard_cnt, guard_cnt_nxt;
    logic       last_owner, last_owner_nxt;
    // Low for the first edge after reset release so that no grant can be
    // issued before the second rising edge.
    logic       ready;
    logic       m0_gnt_q, m1_gnt_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            guard_cnt  <= 8'd0;
            last_owner <= 1'b1;
            ready      <= 1'b0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            guard_cnt  <= guard_cnt_nxt;
            last_owner <= last_owner_nxt;
            ready      <= 1'b1;
            m0_gnt_q   <= (state_nxt == OWN0);
            m1_gnt_q   <= (state_nxt == OWN1);
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt      = state;
        guard_cnt_nxt  = guard_cnt;
        last_owner_nxt = last_owner;
        unique case (state)
            IDLE: begin
                if (ready) begin
                    if (bus.m0_req && bus.m1_req)
                        // Tie goes to whoever did not own last.
                        state_nxt = last_owner ? OWN0 : OWN1;
                    else if (bus.m0_req)
                        state_nxt = OWN0;
                    else if (bus.m1_req)
                        state_nxt = OWN1;
                end
            end
            OWN0: begin
                // Release only with cs high so an in-flight transfer is
                // never cut short by an early request drop.
                if (!bus.m0_req && bus.m0_cs) begin
                    state_nxt      = GUARD;
                    guard_cnt_nxt  = GUARD_LOAD;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (!bus.m1_req && bus.m1_cs) begin
                    state_nxt      = GUARD;
                    guard_cnt_nxt  = GUARD_LOAD;
                    last_owner_nxt = 1'b1;
                end
            end
            GUARD: begin
                if (guard_cnt == 8'd0)
                    state_nxt = IDLE;
                else
                    guard_cnt_nxt = guard_cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- pin mux ----------------
    // Driven from the state register alone, so reset forces the idle pin
    // values immediately without waiting for a clock edge.
    logic fcs, fsck, fmosi, miso0, miso1;

    always_comb begin
        fcs   = 1'b1;
        fsck  = 1'b0;
        fmosi = 1'b0;
        miso0 = 1'b0;
        miso1 = 1'b0;
        unique case (state)
            OWN0: begin
                fcs   = bus.m0_cs;
                fsck  = bus.m0_sck;
                fmosi = bus.m0_mosi;
                miso0 = bus.flash_miso;
            end
            OWN1: begin
                fcs   = bus.m1_cs;
                fsck  = bus.m1_sck;
                fmosi = bus.m1_mosi;
                miso1 = bus.flash_miso;
            end
            default: ;
        endcase
    end

    assign bus.flash_cs   = fcs;
    assign bus.flash_sck  = fsck;
    assign bus.flash_mosi = fmosi;
    assign bus.m0_miso    = miso0;
    assign bus.m1_miso    = miso1;
    assign bus.m0_gnt     = m0_gnt_q;
    assign bus.m1_gnt     = m1_gnt_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_hadbadge_flash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hadbadge_flash_arbiter
// Directed scenarios followed by randomized traffic, all checked against an
// ownership/timeline model: who owns the flash, the edge at which the last
// guard interval ends, and the earliest edge a new grant may be made.
// ---------------------------------------------------------------------------
module tb_hadbadge_flash_arbiter;
    localparam int G = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hadbadge_flash_arbiter_if bus();

    hadbadge_flash_arbiter #(.GUARD_CYCLES(G)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference timeline model.
    int owner;       // -1 none, 0 or 1
    int last;        // last requester to release
    int k;           // rising edges since reset release
    int guard_end;   // first edge after which the arbiter is idle again
    int next_grant;  // earliest edge at which a grant may be issued

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner      = -1;
        last       = 1;
        k          = 0;
        guard_end  = 0;
        next_grant = 2;
    endtask

    task automatic model_release(input int x);
        last       = x;
        owner      = -1;
        guard_end  = k + G;
        next_grant = k + G + 1;
    endtask

    // Advances the model over one rising edge using the inputs now applied.
    task automatic model_edge();
        k++;
        if (owner == 0) begin
            if (!bus.m0_req && bus.m0_cs) model_release(0);
        end else if (owner == 1) begin
            if (!bus.m1_req && bus.m1_cs) model_release(1);
        end else if (k >= next_grant) begin
            if (bus.m0_req && bus.m1_req) owner = 1 - last;
            else if (bus.m0_req)          owner = 0;
            else if (bus.m1_req)          owner = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp, got;
        logic fcs, fsck, fmosi;
        fcs = 1'b1; fsck = 1'b0; fmosi = 1'b0;
        if (owner == 0)      {fcs, fsck, fmosi} = {bus.m0_cs, bus.m0_sck, bus.m0_mosi};
        else if (owner == 1) {fcs, fsck, fmosi} = {bus.m1_cs, bus.m1_sck, bus.m1_mosi};
        exp = {owner == 0, owner == 1, (owner >= 0) || (k < guard_end), fcs, fsck, fmosi,
               (owner == 0) ? bus.flash_miso : 1'b0, (owner == 1) ? bus.flash_miso : 1'b0};
        got = {bus.m0_gnt, bus.m1_gnt, bus.busy, bus.flash_cs, bus.flash_sck,
               bus.flash_mosi, bus.m0_miso, bus.m1_miso};
        check(tag, got, exp);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_m0(input logic req, input logic cs, input logic sck, input logic mosi);
        bus.m0_req = req; bus.m0_cs = cs; bus.m0_sck = sck; bus.m0_mosi = mosi;
    endtask

    task automatic set_m1(input logic req, input logic cs, input logic sck, input logic mosi);
        bus.m1_req = req; bus.m1_cs = cs; bus.m1_sck = sck; bus.m1_mosi = mosi;
    endtask

    // Continuous properties, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn) begin
            check("mutex_gnt", {7'd0, bus.m0_gnt & bus.m1_gnt}, 8'd0);
            if (!bus.m0_gnt && !bus.m1_gnt)
                check("cs_high_unowned", {7'd0, bus.flash_cs}, 8'd1);
        end
    end

    initial begin
        set_m0(0, 1, 0, 0);
        set_m1(0, 1, 0, 0);
        bus.flash_miso = 1'b0;
        model_reset();
        #1;
        check_all("reset");

        // Tie straight out of reset: no grant on edge 1, m0 on edge 2.
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        #11 resetn = 1'b1;
        step("tie_e1");
        check("no_gnt_edge1", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'd0);
        step("tie_e2");
        check("tie_m0_wins", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'b10);

        // m0 transfer while m1 intrudes with its own pins.
        for (int i = 0; i < 6; i++) begin
            set_m0(1, 0, i[0], i[1]);
            set_m1(1, 0, ~i[0], ~i[1]);
            bus.flash_miso = i[0] ^ i[2];
            #1;
            check_all("xfer_comb");
            check("intrude_sck", {7'd0, bus.flash_sck}, {7'd0, i[0]});
            step("xfer_m0");
        end

        // Early request drop with cs low keeps ownership.
        set_m0(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("early_drop");
            check("early_drop_gnt", {7'd0, bus.m0_gnt}, 8'd1);
        end
        set_m1(1, 1, 0, 0);
        set_m0(0, 1, 0, 0);
        step("release_m0");
        check("release_m0_gnt", {7'd0, bus.m0_gnt}, 8'd0);

        // Guard: flash_cs held high, m1 granted after exactly G+1 edges.
        for (int i = 0; i < G; i++) begin
            step("guard");
            check("guard_no_gnt", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'd0);
        end
        step("guard_end");
        check("m1_after_guard", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'b01);

        // m1 transfer, then release with m0 waiting.
        for (int i = 0; i < 3; i++) begin
            set_m1(1, 0, i[0], ~i[0]);
            step("xfer_m1");
        end
        set_m1(0, 1, 0, 0);
        set_m0(1, 1, 0, 0);
        for (int i = 0; i < G + 2; i++) step("m1_to_m0");
        check("m0_regrant", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'b10);

        // m0 releases and re-requests alone: granted again.
        set_m0(0, 1, 0, 0);
        step("m0_rel2");
        set_m0(1, 1, 0, 0);
        for (int i = 0; i < G + 1; i++) step("m0_rereq");
        check("m0_rereq_gnt", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'b10);

        // Reset mid-transfer, then a tie must go to m0 again.
        set_m0(1, 0, 1, 1);
        step("pre_rst");
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check("rst_cs_async", {7'd0, bus.flash_cs}, 8'd1);
        check_all("rst_mid");
        set_m1(1, 1, 0, 0);
        set_m0(1, 1, 0, 0);
        #2 resetn = 1'b1;
        step("post_rst_e1");
        step("post_rst_e2");
        check("post_rst_tie_m0", {6'd0, bus.m0_gnt, bus.m1_gnt}, 8'b10);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            set_m0($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            set_m1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            bus.flash_miso = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) begin
                resetn = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                #1 resetn = 1'b1;
            end else begin
                #1;
                check_all("rand_comb");
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hadbadge_flash_arbiter.md
HADBADGE_FLASH_ARBITER -- requirements
Module: hadbadge_flash_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 4, number of clk cycles flash_cs is held high between two ownerships; legal range 1..255.
REQ-002 Port clk  input  1  system clock, 48 MHz domain; all state SHALL change on its rising edge only.
REQ-003 Port resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Ports m0_req, m1_req  input  1 each  requester asks for flash ownership; m0 is the USB bootloader SPI master, m1 is the secondary master.
REQ-005 Ports m0_gnt, m1_gnt  output  1 each  registered grant; at most one high in any cycle.
REQ-006 Ports m0_cs, m0_sck, m0_mosi, m1_cs, m1_sck, m1_mosi  input  1 each  per-requester SPI pin requests; cs is active-low.
REQ-007 Ports m0_miso, m1_miso  output  1 each  returned flash data.
REQ-008 Ports flash_cs, flash_sck, flash_mosi  output  1 each  shared flash pins; flash_cs is active-low.
REQ-009 Port flash_miso  input  1  flash data out.
REQ-010 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, OWN0, OWN1, GUARD.
REQ-012 IDLE: flash_cs=1, flash_sck=0, flash_mosi=0, both gnt=0.
REQ-013 IDLE with exactly one req high SHALL enter OWNx on the next edge, with gnt asserted in that same cycle (1-cycle req->gnt latency).
REQ-014 IDLE with both req high SHALL grant the requester that did not own last (round robin); last_owner resets to 1, so m0 wins the first tie after reset.
REQ-015 OWNx: flash_cs/sck/mosi SHALL be combinational copies of mx_cs/sck/mosi; mx_miso=flash_miso; the non-owner's miso=0 and its pins are ignored.
REQ-016 OWNx SHALL go to GUARD only on a cycle where mx_req=0 and mx_cs=1; gnt drops on that same edge; last_owner<=x.
REQ-017 Dropping mx_req while mx_cs=0 SHALL NOT truncate the transfer: ownership holds until mx_cs returns high.
REQ-018 Other-requester activity during OWNx SHALL NOT affect the flash pins or the grant.
REQ-019 GUARD: pins as in IDLE; a guard counter loads GUARD_CYCLES-1 on entry and decrements each cycle; at 0 the FSM SHALL go to IDLE.
REQ-020 Requests arriving during GUARD SHALL be honoured from IDLE under REQ-013/014, so the minimum flash_cs-high gap between owners is GUARD_CYCLES+1 cycles.
REQ-021 Round-robin state SHALL update only on release; a requester re-requesting alone SHALL be granted again.
REQ-022 Guard counter width SHALL be 8 bits; no wrap-around is possible within the legal parameter range.

Reset
REQ-023 On resetn low, asynchronously: state=IDLE, m0_gnt=m1_gnt=0, flash_cs=1, flash_sck=0, flash_mosi=0, m0_miso=m1_miso=0, busy=0, guard counter=0, last_owner=1.
REQ-024 Reset asserted mid-transfer SHALL force flash_cs=1 immediately, without waiting for a clock edge.
REQ-025 After resetn deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-026 Single request: m0_req=1 from IDLE -> m0_gnt=1 one cycle later; toggling m0_cs/sck/mosi appears on the flash pins; m1_miso=0.
REQ-027 Tie: both req rise on the same cycle after reset -> m0 granted; m0 releases while m1_req stays high -> flash_cs stays high 5 cycles (GUARD_CYCLES=4), then m1_gnt=1.
REQ-028 Early req drop: m0 drops req with m0_cs=0 -> m0_gnt stays 1 until m0_cs=1, then falls on that edge.
REQ-029 Intrusion: m1 drives m1_cs=0 and toggles m1_sck while m0 owns -> flash pins follow m0 only; m1_gnt=0.
REQ-030 Reset mid-transfer: resetn=0 while OWN0 with m0_cs=0 -> flash_cs=1 in the same cycle; all gnt=0; the next tie is granted to m0.
REQ-031 Continuous assertion for all tests: never m0_gnt&m1_gnt; flash_cs=1 in every IDLE and GUARD cycle.
